sail_mem_write_buffer: RTL and testbench

Synthesizable, parametrised store buffer for emulator memory writes.
- Accepts multi-byte writes from the execution side and queues them in order.
- Drains them byte-serially to the backing byte memory, little-endian: byte i goes to paddr+i.
- Forwards the youngest buffered byte to reads, so that a read issued after a write returns the written value before that write has drained.

---
 rtl/sail_mem_write_buffer.sv | 148 ++++++++++++++
 tb/tb_sail_mem_write_buffer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sail_mem_write_buffer.sv
// sail_mem_write_buffer: in-order store queue draining byte-serially to memory with youngest-byte read forwarding.
// Optional SAIL_MEM_TAG_EN adds per-entry tag storage, tag drain and tag forwarding ports.
module sail_mem_write_buffer #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_BYTES = 8,
   parameter int DEPTH      = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [ADDR_WIDTH-1:0]           wr_addr,
   input  logic [$clog2(DATA_BYTES+1)-1:0] wr_nbytes,
   input  logic [8*DATA_BYTES-1:0]         wr_data,
   output logic                            mem_wr_valid,
   input  logic                            mem_wr_ready,
   output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
   output logic [7:0]                      mem_wr_data,
   input  logic [ADDR_WIDTH-1:0]           rd_addr,
   output logic                            rd_hit,
   output logic [7:0]                      rd_data,
   output logic [$clog2(DEPTH+1)-1:0]      count,
   output logic                            err
`ifdef SAIL_MEM_TAG_EN
   ,
   input  logic                            wr_tag_en,
   input  logic                            wr_tag,
   output logic                            mem_tag_valid,
   output logic                            mem_tag,
   output logic                            rd_tag_hit,
   output logic                            rd_tag
`endif
);
   localparam int NBW = $clog2(DATA_BYTES+1);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int PW  = $clog2(DEPTH);
   localparam int IW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   typedef enum logic {IDLE, DRAIN} state_t;

   logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
   logic [NBW-1:0]          nb_q   [DEPTH];
   logic [8*DATA_BYTES-1:0] data_q [DEPTH];
   logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]           count_q, count_d;
   logic [IW-1:0]           idx_q, idx_d;
   state_t                  state_q, state_d;
   logic                    err_q, err_d, legal, push, beat, pop;
   logic [DEPTH-1:0]        hit_v, live_v;
   logic [7:0]              byte_v [DEPTH];
   logic [PW-1:0]           age_v  [DEPTH];
   logic [ADDR_WIDTH-1:0]   off_v  [DEPTH];
`ifdef SAIL_MEM_TAG_EN
   logic                    tag_en_q [DEPTH];
   logic                    tag_q    [DEPTH];
   logic [DEPTH-1:0]        thit_v;
`endif

   assign wr_ready = rst_n && count_q != CW'(DEPTH);

   always_comb begin
      legal   = wr_nbytes != '0 && wr_nbytes <= NBW'(DATA_BYTES);
      push    = wr_valid & wr_ready & legal;
      beat    = state_q == DRAIN && mem_wr_ready;
      pop     = beat && NBW'(idx_q) == nb_q[rp_q] - NBW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      wp_d    = wp_q + PW'(push);
      rp_d    = rp_q + PW'(pop);
      idx_d   = pop ? '0 : idx_q + IW'(beat);
      err_d   = err_q | (wr_valid & wr_ready & ~legal);
      state_d = count_d != '0 ? DRAIN : IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wp_q] <= wr_addr;
         nb_q[wp_q]   <= wr_nbytes;
         data_q[wp_q] <= wr_data;
`ifdef SAIL_MEM_TAG_EN
         tag_en_q[wp_q] <= wr_tag_en;
         tag_q[wp_q]    <= wr_tag;
`endif
      end
   end

   assign mem_wr_valid = state_q == DRAIN;
   assign mem_wr_addr  = mem_wr_valid ? addr_q[rp_q] + ADDR_WIDTH'(idx_q) : '0;
   assign mem_wr_data  = mem_wr_valid ? data_q[rp_q][{idx_q, 3'b000} +: 8] : '0;
   assign count        = count_q;
   assign err          = err_q;

   // Age 0 is the head; its already-drained bytes (offset < idx) must not forward.
   for (genvar j = 0; j < DEPTH; j++) begin : g_fwd
      assign age_v[j]  = PW'(j) - rp_q;
      assign off_v[j]  = rd_addr - addr_q[j];
      assign live_v[j] = CW'(age_v[j]) < count_q;
      assign hit_v[j]  = live_v[j] && off_v[j] < ADDR_WIDTH'(nb_q[j]) &&
                         (age_v[j] != '0 || off_v[j] >= ADDR_WIDTH'(idx_q));
      assign byte_v[j] = data_q[j][{off_v[j][IW-1:0], 3'b000} +: 8];
`ifdef SAIL_MEM_TAG_EN
      assign thit_v[j] = live_v[j] && tag_en_q[j] && addr_q[j] == rd_addr;
`endif
   end

   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
`ifdef SAIL_MEM_TAG_EN
      rd_tag_hit = 1'b0;
      rd_tag     = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         if (hit_v[rp_q + PW'(i)]) begin
            rd_hit  = 1'b1;
            rd_data = byte_v[rp_q + PW'(i)];
         end
`ifdef SAIL_MEM_TAG_EN
         if (thit_v[rp_q + PW'(i)]) begin
            rd_tag_hit = 1'b1;
            rd_tag     = tag_q[rp_q + PW'(i)];
         end
`endif
      end
   end

`ifdef SAIL_MEM_TAG_EN
   assign mem_tag_valid = mem_wr_valid && idx_q == '0 && tag_en_q[rp_q];
   assign mem_tag       = mem_tag_valid && tag_q[rp_q];
`endif
endmodule

// File: tb/tb_sail_mem_write_buffer.sv
// tb_sail_mem_write_buffer: table-driven per-cycle vectors plus a fill/overlap sequence.
module tb_sail_mem_write_buffer;
   logic        clk = 1'b0;
   logic        rst_n, wr_valid, wr_ready, mem_wr_valid, mem_wr_ready, rd_hit, err;
   logic [63:0] wr_addr, wr_data, mem_wr_addr, rd_addr;
   logic [3:0]  wr_nbytes, count;
   logic [7:0]  mem_wr_data, rd_data;
   int          n_vec = 0, n_bad = 0;

   sail_mem_write_buffer dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_nbytes(wr_nbytes), .wr_data(wr_data),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, wv;
      logic [63:0] wa;
      logic [3:0]  wn;
      logic [63:0] wd;
      logic        mr;
      logic [63:0] ra;
      logic        chk, ev;
      logic [63:0] ea;
      logic [7:0]  ed;
      logic [3:0]  ec;
      logic        ewr, eh;
      logic [7:0]  erd;
      logic        eerr;
   } vec_t;

   localparam int NV = 40;
   vec_t tbl [NV];

   task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      tbl = '{
         '{1'b0,1'b0,64'h0,4'd0,64'h0,1'b0,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b0,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b0,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h1000,4'd4,64'hDDCCBBAA,1'b1,64'h1002,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h1002,1'b1, 1'b1,64'h1000,8'hAA,4'd1,1'b1,1'b1,8'hCC,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h1000,1'b1, 1'b1,64'h1001,8'hBB,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h1002,1'b1, 1'b1,64'h1002,8'hCC,4'd1,1'b1,1'b1,8'hCC,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h1003,1'b1, 1'b1,64'h1003,8'hDD,4'd1,1'b1,1'b1,8'hDD,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h1003,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h1000,4'd4,64'hDDCCBBAA,1'b0,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h1000,8'hAA,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b0,64'h0,1'b1, 1'b1,64'h1001,8'hBB,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b0,64'h0,1'b1, 1'b1,64'h1001,8'hBB,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h1001,8'hBB,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h1002,8'hCC,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h1003,8'hDD,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h2000,4'd2,64'h1111,1'b0,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h2001,4'd1,64'h22,1'b0,64'h0,1'b1, 1'b1,64'h2000,8'h11,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b0,64'h2001,1'b1, 1'b1,64'h2000,8'h11,4'd2,1'b1,1'b1,8'h22,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b0,64'h2002,1'b1, 1'b1,64'h2000,8'h11,4'd2,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h2000,1'b1, 1'b1,64'h2000,8'h11,4'd2,1'b1,1'b1,8'h11,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h2001,1'b1, 1'b1,64'h2001,8'h11,4'd2,1'b1,1'b1,8'h22,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h2000,1'b1, 1'b1,64'h2001,8'h22,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'hFFFF_FFFF_FFFF_FFFF,4'd2,64'h5AA5,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'hFFFF_FFFF_FFFF_FFFF,8'hA5,4'd1,1'b1,1'b1,8'h5A,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'hFFFF_FFFF_FFFF_FFFF,1'b1, 1'b1,64'h0,8'h5A,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h6000,4'd0,64'hFF,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b1},
         '{1'b1,1'b1,64'h6000,4'd9,64'hFF,1'b1,64'h6000,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b1},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h6000,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b1},
         '{1'b1,1'b1,64'h3000,4'd4,64'h44332211,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b1},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h3000,8'h11,4'd1,1'b1,1'b0,8'h00,1'b1},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b1,64'h3001,8'h22,4'd1,1'b1,1'b0,8'h00,1'b1},
         '{1'b0,1'b0,64'h0,4'd0,64'h0,1'b1,64'h3002,1'b0, 1'b0,64'h0,8'h00,4'd0,1'b0,1'b0,8'h00,1'b0},
         '{1'b0,1'b0,64'h0,4'd0,64'h0,1'b1,64'h3002,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b0,1'b0,8'h00,1'b0},
         '{1'b1,1'b1,64'h4000,4'd1,64'h77,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h3002,1'b1, 1'b1,64'h4000,8'h77,4'd1,1'b1,1'b0,8'h00,1'b0},
         '{1'b1,1'b0,64'h0,4'd0,64'h0,1'b1,64'h0,1'b1, 1'b0,64'h0,8'h00,4'd0,1'b1,1'b0,8'h00,1'b0}
      };
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_nbytes = '0; wr_data = '0;
      mem_wr_ready = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst_n = tbl[i].rst_n; wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_nbytes = tbl[i].wn;
         wr_data = tbl[i].wd; mem_wr_ready = tbl[i].mr; rd_addr = tbl[i].ra;
         #1;
         if (tbl[i].chk)
            check($sformatf("vec[%0d]", i),
                  {mem_wr_valid, mem_wr_addr, mem_wr_data, count, wr_ready, rd_hit, rd_data, err},
                  {tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].ec, tbl[i].ewr, tbl[i].eh, tbl[i].erd, tbl[i].eerr});
      end
      // Fill all 8 entries with drain stalled, then overlap the 9th write with draining.
      rd_addr = '0; mem_wr_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         wr_valid = 1'b1; wr_addr = 64'h5000 + 64'(i); wr_nbytes = 4'd1; wr_data = 64'(i + 1);
         #1;
         check($sformatf("fill_ready[%0d]", i), 88'(wr_ready), 88'(1));
      end
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         wr_valid = k <= 2; wr_addr = 64'h5008; wr_data = 64'h9; mem_wr_ready = 1'b1;
         #1;
         if (k == 1) check("full_pop_cycle", 88'({wr_ready, count}), 88'({1'b0, 4'd8}));
         if (k == 2) check("full_after_pop", 88'({wr_ready, count}), 88'({1'b1, 4'd7}));
         check($sformatf("drain_order[%0d]", k), 88'({mem_wr_valid, mem_wr_addr, mem_wr_data}),
               88'({1'b1, 64'h5000 + 64'(k - 1), 8'(k)}));
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      check("drained_empty", 88'({mem_wr_valid, count}), 88'({1'b0, 4'd0}));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
